// File: rtl/image_buffer_ctrl.sv
`timescale 1ns/1ps
// image_buffer_ctrl: turns a single-port-per-direction BRAM into a circular byte FIFO between the SPI receiver and the LCD driver.
// Define IMAGE_BUFFER_FRAME_CNT_EN to build the frame byte counter and the frame_done pulse.
module image_buffer_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int FRAME_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [7:0]        m_data,
  input  logic              m_ready,
  output logic              bram_we,
  output logic [14:0]       bram_addr_wr,
  output logic [7:0]        bram_data_wr,
  output logic [14:0]       bram_addr_rd,
  input  logic [7:0]        bram_data_rd,
  output logic [ADDR_W:0]   occupancy,
  output logic              overflow,
  output logic              frame_done
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   occ;
  logic              in_flight;
  logic [1:0]        held;
  logic [1:0]        held_nx;
  logic [1:0]        slots;
  logic [7:0]        ent0;
  logic [7:0]        ent1;
  logic [7:0]        ent0_nx;
  logic [7:0]        ent1_nx;
  logic              accept;
  logic              pop;
  logic              issue;

  assign s_ready      = rst_n & (occ != DEPTH) & ~frame_start;
  assign accept       = s_valid & s_ready;
  assign bram_we      = accept;
  assign bram_addr_wr = 15'(wr_ptr);
  assign bram_data_wr = s_data;
  assign occupancy    = occ;

  // The returning byte is presented directly while the stage is empty, giving the two-cycle latency.
  assign m_valid = (held != 2'd0) | in_flight;
  assign m_data  = (held != 2'd0) ? ent0 : (in_flight ? bram_data_rd : 8'h00);
  assign pop     = m_valid & m_ready;

  // Entries still occupied after this cycle; a same-cycle pop frees a slot for back-to-back reads.
  assign slots = held + {1'b0, in_flight} - {1'b0, pop};
  assign issue = (occ != '0) & (slots < 2'd2) & ~frame_start;

  assign bram_addr_rd = 15'(issue ? rd_ptr : rd_addr_q);

  always_comb begin
    ent0_nx = ent0;
    ent1_nx = ent1;
    held_nx = held;
    if (in_flight) begin
      if (held == 2'd0) ent0_nx = bram_data_rd;
      else              ent1_nx = bram_data_rd;
      held_nx = held + 2'd1;
    end
    if (pop) begin
      ent0_nx = ent1_nx;
      held_nx = held_nx - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_addr_q <= '0;
      occ       <= '0;
      in_flight <= 1'b0;
      held      <= 2'd0;
      overflow  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      in_flight <= 1'b0;
      held      <= 2'd0;
      overflow  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (issue) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        rd_addr_q <= rd_ptr;
      end
      occ       <= occ + (ADDR_W+1)'(accept) - (ADDR_W+1)'(issue);
      in_flight <= issue;
      held      <= held_nx;
      if (s_valid & ~s_ready) overflow <= 1'b1;
    end
  end

  // Entry contents need no reset: held gates their visibility.
  always_ff @(posedge clk) begin
    ent0 <= ent0_nx;
    ent1 <= ent1_nx;
  end

`ifdef IMAGE_BUFFER_FRAME_CNT_EN
  localparam int FCW = $clog2(FRAME_BYTES + 1);

  logic [FCW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (frame_cnt == FCW'(FRAME_BYTES - 1)) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end
`else
  assign frame_done = 1'b0;
`endif

endmodule
